mux_arbiter: RTL and testbench
==============================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter DATA_W, default 1: width of each requester data input and of output y.
REQ-002 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles while another requester is waiting; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  4  request per requester; bit i corresponds to data input i.
REQ-006 din_a, din_b, din_c, din_d  input  DATA_W each  requester data 0..3.
REQ-007 gnt  output  4  registered one-hot grant, or all zero.
REQ-008 sel  output  2  registered encoded index of the granted requester.
REQ-009 valid  output  1  registered; high when y carries granted data.
REQ-010 y  output  DATA_W  registered muxed data.

Function
REQ-011 The FSM SHALL have two states: IDLE (no grant) and GRANT (one requester owns the mux).
REQ-012 In IDLE with req==0, the block SHALL remain in IDLE with gnt=0.
REQ-013 IDLE->GRANT: when req!=0, the next edge SHALL set gnt to the first set req bit searching from ptr upward modulo 4, set sel to its index, and clear hold_cnt.
REQ-014 In GRANT, while req[sel]=1 and no other req bit is set, the grant SHALL persist indefinitely; hold_cnt saturates at MAX_HOLD-1.
REQ-015 In GRANT, while req[sel]=1, another req bit is set and hold_cnt<MAX_HOLD-1, the grant SHALL persist and hold_cnt SHALL increment.
REQ-016 In GRANT, when req[sel]=1, another req bit is set and hold_cnt==MAX_HOLD-1, the next edge SHALL grant the next requesting index after sel (round-robin), with no idle cycle.
REQ-017 In GRANT, when req[sel]=0 and another req bit is set, the next edge SHALL grant the next requesting index after sel, with no idle cycle.
REQ-018 In GRANT, when req==0, the next edge SHALL clear gnt and return to IDLE.
REQ-019 ptr SHALL be updated to (granted index + 1) mod 4 on every new grant.
REQ-020 gnt and sel SHALL change only on clock edges; gnt is always one-hot in GRANT and zero in IDLE.
REQ-021 Data latency: valid SHALL equal the previous cycle's |gnt, and y SHALL equal the din selected by the previous cycle's sel; y SHALL be 0 when valid=0.
REQ-022 Requests that assert and deassert between edges SHALL be ignored; req is sampled only at rising edges.

Reset
REQ-023 While rst_n=0: state=IDLE, gnt=0, sel=0, valid=0, y=0, hold_cnt=0, ptr=0, applied immediately without a clock.
REQ-024 Reset asserted mid-grant SHALL drop gnt and valid asynchronously; after release, arbitration SHALL restart from ptr=0.
REQ-025 Deassertion of rst_n is synchronised externally; the block SHALL take its first action on the first rising edge after release.

Structure
REQ-026 A shared package mux_arb_pkg SHALL hold the state enum (IDLE, GRANT), constant N_REQ=4 and SEL_W=2.
REQ-027 Round-robin selection SHALL be one combinational sub-module rr_pick: inputs req[3:0] and start[1:0]; outputs found and idx[1:0].
REQ-028 The four-way data selection SHALL be an exhaustive case on sel with a defined default; no latches.

Verification
REQ-029 Single requester: req=4'b0100 held 6 cycles, din_c=1 -> gnt=4'b0100, sel=2 one edge after req; valid=1, y=1 one edge later; grant persists all 6 cycles.
REQ-030 Contention with MAX_HOLD=4: req=4'b0011 held -> gnt=0001 for 4 cycles, then 0010 for 4 cycles, then 0001, no gap cycles.
REQ-031 Early release: grant on 0, req[0] dropped after 2 cycles while req[3]=1 -> gnt=1000 on the next edge, with no idle cycle.
REQ-032 All requests drop: req 0010->0000 -> gnt=0 one edge later; valid=0 and y=0 one further edge later.
REQ-033 Pointer fairness: sequential single grants 2 then all req=1111 -> next grant is index 3, then 0, 1, 2.
REQ-034 Async reset mid-grant: rst_n low between edges during gnt=0100 -> gnt, sel, valid and y go to 0 before the next edge; after release with req=1111, first grant is index 0.

Source files
------------

// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Request/data bundle between requesters and the arbiter; the arbiter uses the slave view.
interface mux_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 1
) ();

  logic [N_REQ-1:0]  req;
  logic [DATA_W-1:0] din_a;
  logic [DATA_W-1:0] din_b;
  logic [DATA_W-1:0] din_c;
  logic [DATA_W-1:0] din_d;
  logic [N_REQ-1:0]  gnt;
  logic [SEL_W-1:0]  sel;
  logic              valid;
  logic [DATA_W-1:0] y;

  modport master (
    output req, din_a, din_b, din_c, din_d,
    input  gnt, sel, valid, y
  );

  modport slave (
    input  req, din_a, din_b, din_c, din_d,
    output gnt, sel, valid, y
  );

endinterface

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit at or after start, wrapping modulo 4.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = start + SEL_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Four-requester round-robin arbiter with a hold limit under contention,
// steering the winner's data onto a registered output one cycle after grant.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_arbiter_if.slave bus
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [3:0]        hold_cnt_q, hold_cnt_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] y_q, y_d;

  logic [N_REQ-1:0]  others;
  logic [N_REQ-1:0]  pick_req;
  logic [SEL_W-1:0]  pick_start;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_found;
  logic              keep_grant;

  assign others = bus.req & ~onehot(sel_q);

  // While granted, search starts after the owner and excludes it.
  always_comb begin
    pick_req   = bus.req;
    pick_start = ptr_q;
    if (state_q == GRANT) begin
      pick_req   = others;
      pick_start = sel_q + SEL_W'(1);
    end
  end

  rr_pick u_rr_pick (
    .req   (pick_req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign keep_grant = bus.req[sel_q] && ((others == '0) || (hold_cnt_q < HOLD_LAST));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = GRANT;
          gnt_d      = onehot(pick_idx);
          sel_d      = pick_idx;
          ptr_d      = pick_idx + SEL_W'(1);
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (bus.req == '0) begin
          state_d    = IDLE;
          gnt_d      = '0;
          hold_cnt_d = '0;
        end else if (keep_grant) begin
          if (hold_cnt_q < HOLD_LAST) begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end
        end else begin
          gnt_d      = onehot(pick_idx);
          sel_d      = pick_idx;
          ptr_d      = pick_idx + SEL_W'(1);
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        gnt_d      = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Data stage lags the grant by one cycle and is forced to zero when nothing was granted.
  always_comb begin
    valid_d = |gnt_q;
    case (sel_q)
      2'd0:    y_d = bus.din_a;
      2'd1:    y_d = bus.din_b;
      2'd2:    y_d = bus.din_c;
      2'd3:    y_d = bus.din_d;
      default: y_d = '0;
    endcase
    if (!valid_d) begin
      y_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      valid_q    <= 1'b0;
      y_q        <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      valid_q    <= valid_d;
      y_q        <= y_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;
  assign bus.y     = y_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: grant sequencing, hold limit, data latency and async reset.
module tb_mux_arbiter;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  logic [3:0] din_v [4];

  mux_arbiter_if #(.DATA_W(4)) bus ();

  mux_arbiter #(.DATA_W(4), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    tick();
    tick();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt got=%b want=0000", bus.gnt); end
    checks++; if (bus.sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_sel got=%0d want=0", bus.sel); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b want=0", bus.valid); end
    checks++; if (bus.y !== 4'h0) begin errors++; $display("[TB] FAIL reset_y got=%h want=0", bus.y); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL idle_noreq_gnt got=%b want=0000", bus.gnt); end
  endtask

  task automatic test_single();
    bus.req = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("[TB] FAIL single_gnt[%0d] got=%b want=0100", i, bus.gnt); end
      checks++; if (bus.sel !== 2'd2) begin errors++; $display("[TB] FAIL single_sel[%0d] got=%0d want=2", i, bus.sel); end
      checks++; if (bus.valid !== (i > 0)) begin errors++; $display("[TB] FAIL single_valid[%0d] got=%b want=%b", i, bus.valid, (i > 0)); end
      checks++; if (bus.y !== ((i > 0) ? din_v[2] : 4'h0)) begin errors++; $display("[TB] FAIL single_y[%0d] got=%h want=%h", i, bus.y, ((i > 0) ? din_v[2] : 4'h0)); end
    end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_all_drop();
    bus.req = 4'b0010;
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("[TB] FAIL drop_gnt got=%b want=0010", bus.gnt); end
    checks++; if (bus.sel !== 2'd1) begin errors++; $display("[TB] FAIL drop_sel got=%0d want=1", bus.sel); end
    tick();
    checks++; if (bus.y !== din_v[1]) begin errors++; $display("[TB] FAIL drop_y_b got=%h want=%h", bus.y, din_v[1]); end
    bus.req = 4'b0000;
    tick();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL drop_gnt_clear got=%b want=0000", bus.gnt); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("[TB] FAIL drop_valid_lag got=%b want=1", bus.valid); end
    tick();
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL drop_valid_clear got=%b want=0", bus.valid); end
    checks++; if (bus.y !== 4'h0) begin errors++; $display("[TB] FAIL drop_y_clear got=%h want=0", bus.y); end
  endtask

  task automatic test_contention();
    int exp_idx;
    int prev_idx;
    logic [3:0] exp_gnt;
    logic [3:0] exp_y;
    bus.req = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_idx  = ((i / 4) % 2 == 0) ? 0 : 1;
      prev_idx = (((i - 1) / 4) % 2 == 0) ? 0 : 1;
      exp_gnt  = 4'b0001 << exp_idx;
      exp_y    = (i == 0) ? 4'h0 : din_v[prev_idx];
      checks++; if (bus.gnt !== exp_gnt) begin errors++; $display("[TB] FAIL contend_gnt[%0d] got=%b want=%b", i, bus.gnt, exp_gnt); end
      checks++; if (bus.y !== exp_y) begin errors++; $display("[TB] FAIL contend_y[%0d] got=%h want=%h", i, bus.y, exp_y); end
    end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_early_release();
    bus.req = 4'b0001;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("[TB] FAIL early_gnt0 got=%b want=0001", bus.gnt); end
    bus.req = 4'b1001;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("[TB] FAIL early_hold got=%b want=0001", bus.gnt); end
    bus.req = 4'b1000;
    tick();
    checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("[TB] FAIL early_switch got=%b want=1000", bus.gnt); end
    checks++; if (bus.sel !== 2'd3) begin errors++; $display("[TB] FAIL early_sel got=%0d want=3", bus.sel); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("[TB] FAIL early_nogap got=%b want=1", bus.valid); end
    tick();
    checks++; if (bus.y !== din_v[3]) begin errors++; $display("[TB] FAIL early_y_d got=%h want=%h", bus.y, din_v[3]); end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_fairness();
    int exp_idx;
    logic [3:0] exp_gnt;
    bus.req = 4'b0100;
    tick();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("[TB] FAIL fair_first got=%b want=0100", bus.gnt); end
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b1111;
    for (int i = 0; i < 13; i++) begin
      tick();
      exp_idx = (3 + i / 4) % 4;
      exp_gnt = 4'b0001 << exp_idx;
      checks++; if (bus.gnt !== exp_gnt) begin errors++; $display("[TB] FAIL fair_gnt[%0d] got=%b want=%b", i, bus.gnt, exp_gnt); end
      checks++; if (bus.sel !== 2'(exp_idx)) begin errors++; $display("[TB] FAIL fair_sel[%0d] got=%0d want=%0d", i, bus.sel, exp_idx); end
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL areset_gnt got=%b want=0000", bus.gnt); end
    checks++; if (bus.sel !== 2'd0) begin errors++; $display("[TB] FAIL areset_sel got=%0d want=0", bus.sel); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid got=%b want=0", bus.valid); end
    checks++; if (bus.y !== 4'h0) begin errors++; $display("[TB] FAIL areset_y got=%h want=0", bus.y); end
    tick();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL areset_held got=%b want=0000", bus.gnt); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("[TB] FAIL areset_restart got=%b want=0001", bus.gnt); end
    checks++; if (bus.sel !== 2'd0) begin errors++; $display("[TB] FAIL areset_restart_sel got=%0d want=0", bus.sel); end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_glitch();
    #1;
    bus.req = 4'b0010;
    #2;
    bus.req = 4'b0000;
    tick();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL glitch_gnt got=%b want=0000", bus.gnt); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL glitch_valid got=%b want=0", bus.valid); end
  endtask

  task automatic test_back_to_back();
    bus.req = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("[TB] FAIL alone_gnt[%0d] got=%b want=0001", i, bus.gnt); end
    end
    bus.req = 4'b0011;
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("[TB] FAIL sat_switch got=%b want=0010", bus.gnt); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("[TB] FAIL sat_nogap got=%b want=1", bus.valid); end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    din_v[0] = 4'hA;
    din_v[1] = 4'h5;
    din_v[2] = 4'h1;
    din_v[3] = 4'h7;
    bus.din_a = din_v[0];
    bus.din_b = din_v[1];
    bus.din_c = din_v[2];
    bus.din_d = din_v[3];
    test_reset();
    test_single();
    test_all_drop();
    test_contention();
    test_early_release();
    test_fairness();
    test_async_reset();
    test_glitch();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
